// File: rtl/id_ex_issue_if.sv
// ID->EX issue bus: the registered decoded fields and operands that feed ex_stage.
// The issue register drives it through master; ex_stage reads it through slave.
interface id_ex_issue_if #(
   parameter int XLEN = 32
);
   logic [XLEN-1:0] id_ex_PC;
   logic [XLEN-1:0] id_ex_imm;
   logic [XLEN-1:0] id_ex_rega;
   logic [XLEN-1:0] id_ex_regb;
   logic [XLEN-1:0] pc_add_opa;
   logic [1:0]      id_ex_opa_select;
   logic [1:0]      id_ex_opb_select;
   logic [4:0]      id_ex_alu_func;
   logic [2:0]      id_ex_funct3;
   logic            id_ex_uncond_branch;
   logic            id_ex_cond_branch;
   logic            id_ex_valid_inst;
   logic [4:0]      id_ex_rd;
   logic            id_ex_rd_wr;
   logic            id_ex_is_load;

   modport master (
      output id_ex_PC, id_ex_imm, id_ex_rega, id_ex_regb, pc_add_opa,
             id_ex_opa_select, id_ex_opb_select, id_ex_alu_func, id_ex_funct3,
             id_ex_uncond_branch, id_ex_cond_branch, id_ex_valid_inst,
             id_ex_rd, id_ex_rd_wr, id_ex_is_load
   );

   modport slave (
      input  id_ex_PC, id_ex_imm, id_ex_rega, id_ex_regb, pc_add_opa,
             id_ex_opa_select, id_ex_opb_select, id_ex_alu_func, id_ex_funct3,
             id_ex_uncond_branch, id_ex_cond_branch, id_ex_valid_inst,
             id_ex_rd, id_ex_rd_wr, id_ex_is_load
   );
endinterface

// File: rtl/id_ex_issue.sv
// ID->EX issue register with EX/MEM and WB operand forwarding, load-use bubbles,
// downstream hold on mem_stall and a wrong-path kill window after a taken branch.
module id_ex_issue #(
   parameter int XLEN      = 32,
   parameter int BR_SHADOW = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_valid,
   input  logic [XLEN-1:0] id_PC,
   input  logic [XLEN-1:0] id_imm,
   input  logic [XLEN-1:0] id_rega,
   input  logic [XLEN-1:0] id_regb,
   input  logic [4:0]      id_rs1,
   input  logic [4:0]      id_rs2,
   input  logic            id_rs1_used,
   input  logic            id_rs2_used,
   input  logic [4:0]      id_rd,
   input  logic            id_rd_wr,
   input  logic            id_is_load,
   input  logic            id_jalr,
   input  logic [1:0]      id_opa_select,
   input  logic [1:0]      id_opb_select,
   input  logic [4:0]      id_alu_func,
   input  logic [2:0]      id_funct3,
   input  logic            id_uncond_branch,
   input  logic            id_cond_branch,
   input  logic            ex_take_branch,
   input  logic            mem_stall,
   input  logic [4:0]      ex_mem_rd,
   input  logic            ex_mem_rd_wr,
   input  logic            ex_mem_is_load,
   input  logic [XLEN-1:0] ex_mem_result,
   input  logic [4:0]      wb_rd,
   input  logic            wb_wr,
   input  logic [XLEN-1:0] wb_data,
   output logic            id_stall,
   id_ex_issue_if.master   ex_bus
);

   localparam int CNT_W = (BR_SHADOW > 1) ? $clog2(BR_SHADOW) + 1 : 1;

   typedef enum logic {
      S_RUN   = 1'b0,
      S_FLUSH = 1'b1
   } state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             flush_p0;
   logic             load_use_p0;
   logic             bubble_p0;
   logic             issue_p0;
   logic [XLEN-1:0]  rega_fwd_p0;
   logic [XLEN-1:0]  regb_fwd_p0;

   // EX/MEM beats WB; x0 always reads the regfile value untouched.
   function automatic logic [XLEN-1:0] fwd_operand(
      input logic [4:0]      rs,
      input logic [XLEN-1:0] rf_val
   );
      if (rs == 5'd0)
         return rf_val;
      if (rs == ex_mem_rd && ex_mem_rd_wr && !ex_mem_is_load)
         return ex_mem_result;
      if (rs == wb_rd && wb_wr)
         return wb_data;
      return rf_val;
   endfunction

   function automatic logic load_hit(
      input logic [4:0] rs,
      input logic       used
   );
      logic in_ex;
      logic in_mem;
      in_ex  = (rs == ex_bus.id_ex_rd) && ex_bus.id_ex_is_load && ex_bus.id_ex_valid_inst;
      in_mem = (rs == ex_mem_rd) && ex_mem_is_load && ex_mem_rd_wr;
      return used && (rs != 5'd0) && (in_ex || in_mem);
   endfunction

   // ID stage: hazard detection and operand selection
   always_comb begin
      rega_fwd_p0 = fwd_operand(id_rs1, id_rega);
      regb_fwd_p0 = fwd_operand(id_rs2, id_regb);
      flush_p0    = (state == S_RUN) && ex_take_branch && !mem_stall;
      load_use_p0 = (state == S_RUN) && id_valid &&
                    (load_hit(id_rs1, id_rs1_used) || load_hit(id_rs2, id_rs2_used));
      id_stall    = (load_use_p0 && !flush_p0 && !mem_stall) || mem_stall;
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      bubble_p0 = 1'b0;
      issue_p0  = 1'b0;
      if (mem_stall) begin
         state_n = state;
      end else if (state == S_FLUSH) begin
         bubble_p0 = 1'b1;
         cnt_n     = cnt - CNT_W'(1);
         if (cnt == CNT_W'(1))
            state_n = S_RUN;
      end else if (ex_take_branch) begin
         bubble_p0 = 1'b1;
         cnt_n     = CNT_W'(BR_SHADOW - 1);
         state_n   = (BR_SHADOW > 1) ? S_FLUSH : S_RUN;
      end else if (load_use_p0) begin
         bubble_p0 = 1'b1;
      end else begin
         issue_p0  = 1'b1;
      end
   end

   // ID -> EX register boundary
   always_ff @(posedge clk) begin
      if (!rst) begin
         state                      <= S_RUN;
         cnt                        <= '0;
         ex_bus.id_ex_PC            <= '0;
         ex_bus.id_ex_imm           <= '0;
         ex_bus.id_ex_rega          <= '0;
         ex_bus.id_ex_regb          <= '0;
         ex_bus.pc_add_opa          <= '0;
         ex_bus.id_ex_opa_select    <= '0;
         ex_bus.id_ex_opb_select    <= '0;
         ex_bus.id_ex_alu_func      <= '0;
         ex_bus.id_ex_funct3        <= '0;
         ex_bus.id_ex_uncond_branch <= 1'b0;
         ex_bus.id_ex_cond_branch   <= 1'b0;
         ex_bus.id_ex_valid_inst    <= 1'b0;
         ex_bus.id_ex_rd            <= '0;
         ex_bus.id_ex_rd_wr         <= 1'b0;
         ex_bus.id_ex_is_load       <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (bubble_p0) begin
            ex_bus.id_ex_PC            <= '0;
            ex_bus.id_ex_imm           <= '0;
            ex_bus.id_ex_rega          <= '0;
            ex_bus.id_ex_regb          <= '0;
            ex_bus.pc_add_opa          <= '0;
            ex_bus.id_ex_opa_select    <= '0;
            ex_bus.id_ex_opb_select    <= '0;
            ex_bus.id_ex_alu_func      <= '0;
            ex_bus.id_ex_funct3        <= '0;
            ex_bus.id_ex_uncond_branch <= 1'b0;
            ex_bus.id_ex_cond_branch   <= 1'b0;
            ex_bus.id_ex_valid_inst    <= 1'b0;
            ex_bus.id_ex_rd            <= '0;
            ex_bus.id_ex_rd_wr         <= 1'b0;
            ex_bus.id_ex_is_load       <= 1'b0;
         end else if (issue_p0) begin
            ex_bus.id_ex_PC            <= id_PC;
            ex_bus.id_ex_imm           <= id_imm;
            ex_bus.id_ex_rega          <= rega_fwd_p0;
            ex_bus.id_ex_regb          <= regb_fwd_p0;
            ex_bus.pc_add_opa          <= id_jalr ? rega_fwd_p0 : id_PC;
            ex_bus.id_ex_opa_select    <= id_opa_select;
            ex_bus.id_ex_opb_select    <= id_opb_select;
            ex_bus.id_ex_alu_func      <= id_alu_func;
            ex_bus.id_ex_funct3        <= id_funct3;
            ex_bus.id_ex_uncond_branch <= id_uncond_branch;
            ex_bus.id_ex_cond_branch   <= id_cond_branch;
            ex_bus.id_ex_valid_inst    <= id_valid;
            ex_bus.id_ex_rd            <= id_rd;
            ex_bus.id_ex_rd_wr         <= id_rd_wr;
            ex_bus.id_ex_is_load       <= id_is_load;
         end
      end
   end

endmodule

// File: tb/tb_id_ex_issue.sv
// Directed bench for id_ex_issue: reset, forwarding, load-use bubbles, branch shadow,
// mem_stall hold inside the flush window and x0 handling.
module tb_id_ex_issue;
   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            id_valid;
   logic [XLEN-1:0] id_PC, id_imm, id_rega, id_regb;
   logic [4:0]      id_rs1, id_rs2, id_rd;
   logic            id_rs1_used, id_rs2_used, id_rd_wr, id_is_load, id_jalr;
   logic [1:0]      id_opa_select, id_opb_select;
   logic [4:0]      id_alu_func;
   logic [2:0]      id_funct3;
   logic            id_uncond_branch, id_cond_branch;
   logic            ex_take_branch, mem_stall;
   logic [4:0]      ex_mem_rd;
   logic            ex_mem_rd_wr, ex_mem_is_load;
   logic [XLEN-1:0] ex_mem_result;
   logic [4:0]      wb_rd;
   logic            wb_wr;
   logic [XLEN-1:0] wb_data;
   logic            id_stall;

   int n_cmp = 0;
   int n_err = 0;

   id_ex_issue_if #(.XLEN(XLEN)) bus ();

   id_ex_issue #(.XLEN(XLEN), .BR_SHADOW(2)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_PC(id_PC), .id_imm(id_imm),
      .id_rega(id_rega), .id_regb(id_regb),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd(id_rd), .id_rd_wr(id_rd_wr), .id_is_load(id_is_load), .id_jalr(id_jalr),
      .id_opa_select(id_opa_select), .id_opb_select(id_opb_select),
      .id_alu_func(id_alu_func), .id_funct3(id_funct3),
      .id_uncond_branch(id_uncond_branch), .id_cond_branch(id_cond_branch),
      .ex_take_branch(ex_take_branch), .mem_stall(mem_stall),
      .ex_mem_rd(ex_mem_rd), .ex_mem_rd_wr(ex_mem_rd_wr), .ex_mem_is_load(ex_mem_is_load),
      .ex_mem_result(ex_mem_result),
      .wb_rd(wb_rd), .wb_wr(wb_wr), .wb_data(wb_data),
      .id_stall(id_stall),
      .ex_bus(bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      id_valid = 0; id_PC = '0; id_imm = '0; id_rega = '0; id_regb = '0;
      id_rs1 = '0; id_rs2 = '0; id_rs1_used = 0; id_rs2_used = 0;
      id_rd = '0; id_rd_wr = 0; id_is_load = 0; id_jalr = 0;
      id_opa_select = '0; id_opb_select = '0; id_alu_func = '0; id_funct3 = '0;
      id_uncond_branch = 0; id_cond_branch = 0;
      ex_take_branch = 0; mem_stall = 0;
      ex_mem_rd = '0; ex_mem_rd_wr = 0; ex_mem_is_load = 0; ex_mem_result = '0;
      wb_rd = '0; wb_wr = 0; wb_data = '0;
   endtask

   task automatic test_reset();
      logic any_out;
      rst = 0;
      for (int i = 0; i < 2; i++) begin
         id_valid = 1; id_PC = $urandom; id_imm = $urandom;
         id_rega = $urandom; id_regb = $urandom;
         id_rs1 = 5'($urandom); id_rs2 = 5'($urandom); id_rs1_used = 1; id_rs2_used = 1;
         id_rd = 5'($urandom); id_rd_wr = 1; id_is_load = 1; id_jalr = 1;
         id_opa_select = 2'($urandom); id_opb_select = 2'($urandom);
         id_alu_func = 5'($urandom); id_funct3 = 3'($urandom);
         id_uncond_branch = 1; id_cond_branch = 1;
         ex_take_branch = 1'($urandom); mem_stall = 0;
         ex_mem_rd = 5'($urandom); ex_mem_rd_wr = 1; ex_mem_is_load = 0;
         ex_mem_result = $urandom; wb_rd = 5'($urandom); wb_wr = 1; wb_data = $urandom;
         tick();
      end
      any_out = |{bus.id_ex_PC, bus.id_ex_imm, bus.id_ex_rega, bus.id_ex_regb, bus.pc_add_opa,
                  bus.id_ex_opa_select, bus.id_ex_opb_select, bus.id_ex_alu_func,
                  bus.id_ex_funct3, bus.id_ex_uncond_branch, bus.id_ex_cond_branch,
                  bus.id_ex_valid_inst, bus.id_ex_rd, bus.id_ex_rd_wr, bus.id_ex_is_load};
      n_cmp++;
      if (any_out !== 1'b0) begin
         n_err++;
         $display("FAIL reset_outputs: any bit set=%b PC=%h valid=%b, required all zero",
                  any_out, bus.id_ex_PC, bus.id_ex_valid_inst);
      end
      n_cmp++;
      if (id_stall !== 1'b0) begin
         n_err++;
         $display("FAIL reset_stall: id_stall=%b required 0", id_stall);
      end
      clear_in();
      rst = 1;
      id_valid = 1; id_PC = 32'h0000_0100; id_rd = 5'd1; id_rd_wr = 1;
      tick();
      n_cmp++;
      if (bus.id_ex_valid_inst !== 1'b1 || bus.id_ex_PC !== 32'h0000_0100) begin
         n_err++;
         $display("FAIL first_issue: valid=%b PC=%h required 1 / 00000100",
                  bus.id_ex_valid_inst, bus.id_ex_PC);
      end
   endtask

   task automatic test_forwarding();
      // ADD x3, x1, x2
      clear_in();
      id_valid = 1; id_PC = 32'h104; id_imm = 32'h7;
      id_rs1 = 5'd1; id_rs2 = 5'd2; id_rs1_used = 1; id_rs2_used = 1;
      id_rega = 32'd10; id_regb = 32'd20; id_rd = 5'd3; id_rd_wr = 1;
      id_opa_select = 2'd1; id_opb_select = 2'd2; id_alu_func = 5'd9; id_funct3 = 3'd5;
      id_cond_branch = 1;
      tick();
      n_cmp++;
      if (bus.id_ex_rega !== 32'd10 || bus.id_ex_regb !== 32'd20 || bus.pc_add_opa !== 32'h104) begin
         n_err++;
         $display("FAIL add_operands: rega=%h regb=%h pcop=%h required 0000000a/00000014/00000104",
                  bus.id_ex_rega, bus.id_ex_regb, bus.pc_add_opa);
      end
      n_cmp++;
      if ({bus.id_ex_rd, bus.id_ex_rd_wr, bus.id_ex_opa_select, bus.id_ex_opb_select,
           bus.id_ex_alu_func, bus.id_ex_funct3, bus.id_ex_cond_branch, bus.id_ex_uncond_branch,
           bus.id_ex_imm} !== {5'd3, 1'b1, 2'd1, 2'd2, 5'd9, 3'd5, 1'b1, 1'b0, 32'h7}) begin
         n_err++;
         $display("FAIL add_fields: rd=%0d alu=%0d f3=%0d imm=%h required rd=3 alu=9 f3=5 imm=7",
                  bus.id_ex_rd, bus.id_ex_alu_func, bus.id_ex_funct3, bus.id_ex_imm);
      end
      // SUB using x3 from EX/MEM, jalr-style pc_add_opa
      clear_in();
      id_valid = 1; id_PC = 32'h108; id_rs1 = 5'd3; id_rs2 = 5'd4;
      id_rs1_used = 1; id_rs2_used = 1; id_rega = 32'h111; id_regb = 32'h222;
      id_rd = 5'd6; id_rd_wr = 1; id_jalr = 1;
      ex_mem_rd = 5'd3; ex_mem_rd_wr = 1; ex_mem_result = 32'h55;
      #1;
      n_cmp++;
      if (id_stall !== 1'b0) begin
         n_err++;
         $display("FAIL exmem_fwd_stall: id_stall=%b required 0", id_stall);
      end
      tick();
      n_cmp++;
      if (bus.id_ex_rega !== 32'h55 || bus.id_ex_regb !== 32'h222 || bus.pc_add_opa !== 32'h55) begin
         n_err++;
         $display("FAIL exmem_fwd: rega=%h regb=%h pcop=%h required 00000055/00000222/00000055",
                  bus.id_ex_rega, bus.id_ex_regb, bus.pc_add_opa);
      end
      // EX/MEM and WB both hit x7: EX/MEM wins; x8 only in WB
      clear_in();
      id_valid = 1; id_rs1 = 5'd7; id_rs2 = 5'd8; id_rs1_used = 1; id_rs2_used = 1;
      id_rega = 32'h1; id_regb = 32'h2;
      ex_mem_rd = 5'd7; ex_mem_rd_wr = 1; ex_mem_result = 32'hAA;
      wb_rd = 5'd8; wb_wr = 1; wb_data = 32'hBB;
      tick();
      n_cmp++;
      if (bus.id_ex_rega !== 32'hAA || bus.id_ex_regb !== 32'hBB) begin
         n_err++;
         $display("FAIL wb_fwd: rega=%h regb=%h required 000000aa/000000bb",
                  bus.id_ex_rega, bus.id_ex_regb);
      end
      wb_rd = 5'd7; id_rs2 = 5'd7;
      tick();
      n_cmp++;
      if (bus.id_ex_rega !== 32'hAA || bus.id_ex_regb !== 32'hAA) begin
         n_err++;
         $display("FAIL exmem_over_wb: rega=%h regb=%h required 000000aa/000000aa",
                  bus.id_ex_rega, bus.id_ex_regb);
      end
   endtask

   task automatic test_load_use();
      clear_in();
      id_valid = 1; id_PC = 32'h120; id_rd = 5'd5; id_rd_wr = 1; id_is_load = 1;
      tick();
      clear_in();
      id_valid = 1; id_PC = 32'h124; id_rs1 = 5'd1; id_rs2 = 5'd5;
      id_rs1_used = 1; id_rs2_used = 1; id_rega = 32'h10; id_regb = 32'h9999;
      id_rd = 5'd2; id_rd_wr = 1;
      #1;
      n_cmp++;
      if (id_stall !== 1'b1) begin
         n_err++;
         $display("FAIL lu_stall_ex: id_stall=%b required 1", id_stall);
      end
      tick();
      n_cmp++;
      if (bus.id_ex_valid_inst !== 1'b0 || bus.id_ex_PC !== 32'h0) begin
         n_err++;
         $display("FAIL lu_bubble1: valid=%b PC=%h required 0/00000000",
                  bus.id_ex_valid_inst, bus.id_ex_PC);
      end
      ex_mem_rd = 5'd5; ex_mem_is_load = 1; ex_mem_rd_wr = 1;
      #1;
      n_cmp++;
      if (id_stall !== 1'b1) begin
         n_err++;
         $display("FAIL lu_stall_mem: id_stall=%b required 1", id_stall);
      end
      tick();
      n_cmp++;
      if (bus.id_ex_valid_inst !== 1'b0) begin
         n_err++;
         $display("FAIL lu_bubble2: valid=%b required 0", bus.id_ex_valid_inst);
      end
      ex_mem_rd = 5'd0; ex_mem_is_load = 0; ex_mem_rd_wr = 0;
      wb_rd = 5'd5; wb_wr = 1; wb_data = 32'h1234;
      #1;
      n_cmp++;
      if (id_stall !== 1'b0) begin
         n_err++;
         $display("FAIL lu_release: id_stall=%b required 0", id_stall);
      end
      tick();
      n_cmp++;
      if (bus.id_ex_valid_inst !== 1'b1 || bus.id_ex_regb !== 32'h1234 || bus.id_ex_PC !== 32'h124) begin
         n_err++;
         $display("FAIL lu_issue: valid=%b regb=%h PC=%h required 1/00001234/00000124",
                  bus.id_ex_valid_inst, bus.id_ex_regb, bus.id_ex_PC);
      end
   endtask

   task automatic test_branch();
      // Load-use also present in ID: flush must dominate and keep id_stall low
      clear_in();
      id_valid = 1; id_PC = 32'h130; id_rs1 = 5'd5; id_rs1_used = 1;
      ex_mem_rd = 5'd5; ex_mem_is_load = 1; ex_mem_rd_wr = 1;
      ex_take_branch = 1;
      #1;
      n_cmp++;
      if (id_stall !== 1'b0) begin
         n_err++;
         $display("FAIL br_stall0: id_stall=%b required 0", id_stall);
      end
      tick();
      n_cmp++;
      if (bus.id_ex_valid_inst !== 1'b0 || bus.id_ex_PC !== 32'h0) begin
         n_err++;
         $display("FAIL br_bubble1: valid=%b PC=%h required 0/00000000",
                  bus.id_ex_valid_inst, bus.id_ex_PC);
      end
      ex_take_branch = 0; id_PC = 32'h134;
      #1;
      n_cmp++;
      if (id_stall !== 1'b0) begin
         n_err++;
         $display("FAIL br_stall1: id_stall=%b required 0", id_stall);
      end
      tick();
      n_cmp++;
      if (bus.id_ex_valid_inst !== 1'b0 || bus.id_ex_PC !== 32'h0) begin
         n_err++;
         $display("FAIL br_bubble2: valid=%b PC=%h required 0/00000000",
                  bus.id_ex_valid_inst, bus.id_ex_PC);
      end
      clear_in();
      id_valid = 1; id_PC = 32'h200;
      tick();
      n_cmp++;
      if (bus.id_ex_valid_inst !== 1'b1 || bus.id_ex_PC !== 32'h200) begin
         n_err++;
         $display("FAIL br_target: valid=%b PC=%h required 1/00000200",
                  bus.id_ex_valid_inst, bus.id_ex_PC);
      end
   endtask

   task automatic test_mem_stall_flush();
      clear_in();
      id_valid = 1; id_PC = 32'h300; id_rd = 5'd6; id_rd_wr = 1;
      tick();
      id_PC = 32'h310; mem_stall = 1;
      #1;
      n_cmp++;
      if (id_stall !== 1'b1) begin
         n_err++;
         $display("FAIL ms_stall: id_stall=%b required 1", id_stall);
      end
      tick();
      n_cmp++;
      if (bus.id_ex_valid_inst !== 1'b1 || bus.id_ex_PC !== 32'h300) begin
         n_err++;
         $display("FAIL ms_hold: valid=%b PC=%h required 1/00000300",
                  bus.id_ex_valid_inst, bus.id_ex_PC);
      end
      ex_take_branch = 1;
      tick();
      n_cmp++;
      if (bus.id_ex_valid_inst !== 1'b1 || bus.id_ex_PC !== 32'h300) begin
         n_err++;
         $display("FAIL ms_branch_ignored: valid=%b PC=%h required 1/00000300",
                  bus.id_ex_valid_inst, bus.id_ex_PC);
      end
      mem_stall = 0;
      tick();
      ex_take_branch = 0; mem_stall = 1; id_PC = 32'h400;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++;
         if (id_stall !== 1'b1) begin
            n_err++;
            $display("FAIL ms_flush_stall[%0d]: id_stall=%b required 1", i, id_stall);
         end
         tick();
         n_cmp++;
         if (bus.id_ex_valid_inst !== 1'b0 || bus.id_ex_PC !== 32'h0) begin
            n_err++;
            $display("FAIL ms_flush_hold[%0d]: valid=%b PC=%h required 0/00000000",
                     i, bus.id_ex_valid_inst, bus.id_ex_PC);
         end
      end
      mem_stall = 0;
      tick();
      n_cmp++;
      if (bus.id_ex_valid_inst !== 1'b0 || bus.id_ex_PC !== 32'h0) begin
         n_err++;
         $display("FAIL ms_flush_tail: valid=%b PC=%h required 0/00000000",
                  bus.id_ex_valid_inst, bus.id_ex_PC);
      end
      tick();
      n_cmp++;
      if (bus.id_ex_valid_inst !== 1'b1 || bus.id_ex_PC !== 32'h400) begin
         n_err++;
         $display("FAIL ms_resume: valid=%b PC=%h required 1/00000400",
                  bus.id_ex_valid_inst, bus.id_ex_PC);
      end
   endtask

   task automatic test_x0();
      clear_in();
      id_valid = 1; id_PC = 32'h500; id_rs1 = 5'd0; id_rs2 = 5'd0;
      id_rs1_used = 1; id_rs2_used = 1; id_rega = 32'h77; id_regb = 32'h88;
      ex_mem_rd = 5'd0; ex_mem_rd_wr = 1; ex_mem_result = 32'hdead;
      wb_rd = 5'd0; wb_wr = 1; wb_data = 32'hbeef;
      tick();
      n_cmp++;
      if (bus.id_ex_rega !== 32'h77 || bus.id_ex_regb !== 32'h88) begin
         n_err++;
         $display("FAIL x0_fwd: rega=%h regb=%h required 00000077/00000088",
                  bus.id_ex_rega, bus.id_ex_regb);
      end
      ex_mem_is_load = 1;
      #1;
      n_cmp++;
      if (id_stall !== 1'b0) begin
         n_err++;
         $display("FAIL x0_no_lu: id_stall=%b required 0", id_stall);
      end
   endtask

   task automatic test_invalid_slot();
      clear_in();
      id_valid = 0; id_PC = 32'h600; id_imm = 32'h9; id_rs1 = 5'd5; id_rs1_used = 1;
      ex_mem_rd = 5'd5; ex_mem_is_load = 1; ex_mem_rd_wr = 1;
      #1;
      n_cmp++;
      if (id_stall !== 1'b0) begin
         n_err++;
         $display("FAIL inv_no_lu: id_stall=%b required 0", id_stall);
      end
      tick();
      n_cmp++;
      if (bus.id_ex_valid_inst !== 1'b0 || bus.id_ex_PC !== 32'h600 || bus.id_ex_imm !== 32'h9) begin
         n_err++;
         $display("FAIL inv_capture: valid=%b PC=%h imm=%h required 0/00000600/00000009",
                  bus.id_ex_valid_inst, bus.id_ex_PC, bus.id_ex_imm);
      end
   endtask

   initial begin
      clear_in();
      rst = 0;
      test_reset();
      test_forwarding();
      test_load_use();
      test_branch();
      test_mem_stall_flush();
      test_x0();
      test_invalid_slot();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
